// File: rtl/pe_regfile_param.sv
// pe_regfile_param
// CGRA processing-element register file. Each falling edge it can capture one
// neighbour/bus word and one FU write-back. It serves two combinational
// operands (register or direct channel bypass) and multicasts one register
// onto a masked set of outgoing channels. A valid bit per register, a sticky
// illegal-select flag and a saturating write-collision counter sit alongside.
module pe_regfile_param #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int NCH   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH*DW-1:0] i_ch_in,
  input  logic              i_in_en,
  input  logic [NCH-1:0]    i_in_sel,
  input  logic [AW-1:0]     i_in_addr,
  input  logic              i_wb_en,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [DW-1:0]     i_wb_data,
  input  logic [AW-1:0]     i_rd_addr1,
  input  logic [AW-1:0]     i_rd_addr2,
  input  logic [NCH-1:0]    i_rd_byp1,
  input  logic [NCH-1:0]    i_rd_byp2,
  output logic [DW-1:0]     o_rd_data1,
  output logic [DW-1:0]     o_rd_data2,
  output logic              o_rd_vld1,
  output logic              o_rd_vld2,
  input  logic [AW-1:0]     i_send_addr,
  input  logic [NCH-1:0]    i_send_mask,
  output logic [NCH*DW-1:0] o_ch_out,
  input  logic              i_cfg_clr,
  output logic              o_err,
  output logic [7:0]        o_conflict_cnt
);

  // When DEPTH fills the whole address space every address is legal and the
  // range comparators are not built at all.
  localparam bit POW2 = (DEPTH == (1 << AW));

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic             r_err;
  logic [7:0]       r_conflictCnt;

  logic          w_inOk;
  logic          w_wbOk;
  logic          w_rd1Ok;
  logic          w_rd2Ok;
  logic          w_sendOk;
  logic          w_capLegal;
  logic          w_capWrite;
  logic          w_wbWrite;
  logic          w_conflict;
  logic          w_selBad;
  logic          w_byp1Bad;
  logic          w_byp2Bad;
  logic          w_rangeBad;
  logic          w_errEvent;
  logic [DW-1:0] w_capData;
  logic [DW-1:0] w_rdData1;
  logic [DW-1:0] w_rdData2;
  logic          w_rdVld1;
  logic          w_rdVld2;
  logic [DW-1:0] w_sendData;

  generate
    if (POW2) begin : g_fullRange
      assign w_inOk   = 1'b1;
      assign w_wbOk   = 1'b1;
      assign w_rd1Ok  = 1'b1;
      assign w_rd2Ok  = 1'b1;
      assign w_sendOk = 1'b1;
    end else begin : g_partialRange
      assign w_inOk   = (32'(i_in_addr)   < DEPTH);
      assign w_wbOk   = (32'(i_wb_addr)   < DEPTH);
      assign w_rd1Ok  = (32'(i_rd_addr1)  < DEPTH);
      assign w_rd2Ok  = (32'(i_rd_addr2)  < DEPTH);
      assign w_sendOk = (32'(i_send_addr) < DEPTH);
    end
  endgenerate

  // A capture only writes with a one-hot source and an in-range target; on a
  // same-address collision with a write-back the write-back wins and the
  // capture is dropped and counted.
  assign w_capLegal = i_in_en && $onehot(i_in_sel) && w_inOk;
  assign w_wbWrite  = i_wb_en && w_wbOk;
  assign w_conflict = w_capLegal && w_wbWrite && (i_in_addr == i_wb_addr);
  assign w_capWrite = w_capLegal && !w_conflict;

  // Error sources: malformed selects/bypass codes and out-of-range addresses
  // on any port that is actually being used this cycle.
  assign w_selBad   = i_in_en && !$onehot(i_in_sel);
  assign w_byp1Bad  = (i_rd_byp1 != '0) && !$onehot(i_rd_byp1);
  assign w_byp2Bad  = (i_rd_byp2 != '0) && !$onehot(i_rd_byp2);
  assign w_rangeBad = (i_in_en && !w_inOk) ||
                      (i_wb_en && !w_wbOk) ||
                      ((i_rd_byp1 == '0) && !w_rd1Ok) ||
                      ((i_rd_byp2 == '0) && !w_rd2Ok) ||
                      ((i_send_mask != '0) && !w_sendOk);
  assign w_errEvent = w_selBad || w_byp1Bad || w_byp2Bad || w_rangeBad;

  // Capture source mux; the select is one-hot whenever it is used, so an OR
  // of masked channels is enough.
  always_comb begin
    w_capData = '0;
    for (int k = 0; k < NCH; k++) begin
      if (i_in_sel[k]) begin
        w_capData = w_capData | i_ch_in[k*DW +: DW];
      end
    end
  end

  // Operand 1: register read, single-channel bypass, or zero/invalid for an
  // illegal bypass code.
  always_comb begin
    w_rdData1 = '0;
    w_rdVld1  = 1'b0;
    if (i_rd_byp1 == '0) begin
      if (w_rd1Ok) begin
        w_rdData1 = r_mem[i_rd_addr1];
        w_rdVld1  = r_valid[i_rd_addr1];
      end
    end else if ($onehot(i_rd_byp1)) begin
      w_rdVld1 = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (i_rd_byp1[k]) begin
          w_rdData1 = i_ch_in[k*DW +: DW];
        end
      end
    end
  end

  // Operand 2: same selection rules as operand 1.
  always_comb begin
    w_rdData2 = '0;
    w_rdVld2  = 1'b0;
    if (i_rd_byp2 == '0) begin
      if (w_rd2Ok) begin
        w_rdData2 = r_mem[i_rd_addr2];
        w_rdVld2  = r_valid[i_rd_addr2];
      end
    end else if ($onehot(i_rd_byp2)) begin
      w_rdVld2 = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (i_rd_byp2[k]) begin
          w_rdData2 = i_ch_in[k*DW +: DW];
        end
      end
    end
  end

  assign o_rd_data1 = w_rdData1;
  assign o_rd_data2 = w_rdData2;
  assign o_rd_vld1  = w_rdVld1;
  assign o_rd_vld2  = w_rdVld2;

  // Outgoing channels: the send register is multicast to every masked channel,
  // unmasked channels are driven to zero.
  always_comb begin
    w_sendData = w_sendOk ? r_mem[i_send_addr] : '0;
    o_ch_out   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (i_send_mask[k]) begin
        o_ch_out[k*DW +: DW] = w_sendData;
      end
    end
  end

  // Register array and valid scoreboard, updated on the falling edge; a
  // configuration clear drops the valid bits but same-edge writes re-set theirs.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      if (i_cfg_clr) begin
        r_valid <= '0;
      end
      if (w_capWrite) begin
        r_mem[i_in_addr]   <= w_capData;
        r_valid[i_in_addr] <= 1'b1;
      end
      if (w_wbWrite) begin
        r_mem[i_wb_addr]   <= i_wb_data;
        r_valid[i_wb_addr] <= 1'b1;
      end
    end
  end

  // Sticky error flag; an error in the clearing edge survives the clear.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_errEvent) begin
      r_err <= 1'b1;
    end else if (i_cfg_clr) begin
      r_err <= 1'b0;
    end
  end

  // Saturating collision counter; a collision in the clearing edge restarts
  // the count at one.
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_conflictCnt <= '0;
    end else if (w_conflict) begin
      if (i_cfg_clr) begin
        r_conflictCnt <= 8'd1;
      end else if (r_conflictCnt != 8'hFF) begin
        r_conflictCnt <= r_conflictCnt + 8'd1;
      end
    end else if (i_cfg_clr) begin
      r_conflictCnt <= '0;
    end
  end

  assign o_err          = r_err;
  assign o_conflict_cnt = r_conflictCnt;

endmodule

// File: tb/tb_pe_regfile_param.sv
// tb_pe_regfile_param
// Directed bench for the PE register file: reset, capture, collisions with
// counter saturation, illegal selects, bypass/multicast and clear-vs-write.
module tb_pe_regfile_param;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NCH   = 4;

  logic              i_clk;
  logic              i_rst;
  logic [NCH*DW-1:0] i_ch_in;
  logic              i_in_en;
  logic [NCH-1:0]    i_in_sel;
  logic [AW-1:0]     i_in_addr;
  logic              i_wb_en;
  logic [AW-1:0]     i_wb_addr;
  logic [DW-1:0]     i_wb_data;
  logic [AW-1:0]     i_rd_addr1;
  logic [AW-1:0]     i_rd_addr2;
  logic [NCH-1:0]    i_rd_byp1;
  logic [NCH-1:0]    i_rd_byp2;
  logic [DW-1:0]     o_rd_data1;
  logic [DW-1:0]     o_rd_data2;
  logic              o_rd_vld1;
  logic              o_rd_vld2;
  logic [AW-1:0]     i_send_addr;
  logic [NCH-1:0]    i_send_mask;
  logic [NCH*DW-1:0] o_ch_out;
  logic              i_cfg_clr;
  logic              o_err;
  logic [7:0]        o_conflict_cnt;

  int nCompared;
  int nMismatched;

  pe_regfile_param #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NCH(NCH)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_ch_in        (i_ch_in),
    .i_in_en        (i_in_en),
    .i_in_sel       (i_in_sel),
    .i_in_addr      (i_in_addr),
    .i_wb_en        (i_wb_en),
    .i_wb_addr      (i_wb_addr),
    .i_wb_data      (i_wb_data),
    .i_rd_addr1     (i_rd_addr1),
    .i_rd_addr2     (i_rd_addr2),
    .i_rd_byp1      (i_rd_byp1),
    .i_rd_byp2      (i_rd_byp2),
    .o_rd_data1     (o_rd_data1),
    .o_rd_data2     (o_rd_data2),
    .o_rd_vld1      (o_rd_vld1),
    .o_rd_vld2      (o_rd_vld2),
    .i_send_addr    (i_send_addr),
    .i_send_mask    (i_send_mask),
    .o_ch_out       (o_ch_out),
    .i_cfg_clr      (i_cfg_clr),
    .o_err          (o_err),
    .o_conflict_cnt (o_conflict_cnt)
  );

  // Free-running clock; the DUT updates on the falling edge.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Return every stimulus input to a quiet state.
  task automatic idle();
    i_ch_in     = '0;
    i_in_en     = 1'b0;
    i_in_sel    = '0;
    i_in_addr   = '0;
    i_wb_en     = 1'b0;
    i_wb_addr   = '0;
    i_wb_data   = '0;
    i_rd_addr1  = '0;
    i_rd_addr2  = '0;
    i_rd_byp1   = '0;
    i_rd_byp2   = '0;
    i_send_addr = '0;
    i_send_mask = '0;
    i_cfg_clr   = 1'b0;
  endtask

  // Let one falling edge commit the current inputs, then settle.
  task automatic commit();
    @(negedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    // Dirty the state first: a register, the error flag and the counter.
    i_in_en = 1'b1; i_in_sel = 4'b0001; i_ch_in[0*DW +: DW] = 32'h0BAD_0BAD;
    i_in_addr = 6'd12; i_wb_en = 1'b1; i_wb_addr = 6'd12; i_wb_data = 32'h0000_1111;
    commit();
    idle();
    i_in_en = 1'b1; i_in_sel = 4'b0011;
    commit();
    idle();
    // Pending write-back is aborted by reset asserted before its edge.
    @(posedge i_clk); #1;
    i_wb_en = 1'b1; i_wb_addr = 6'd20; i_wb_data = 32'hDEAD_BEEF;
    #2 i_rst = 1'b1;
    @(negedge i_clk); #1;
    idle();
    i_rd_addr1 = 6'd12; i_rd_addr2 = 6'd20; i_send_addr = 6'd12; i_send_mask = 4'b1111;
    #1;
    nCompared++;
    if (o_rd_data1 !== 32'h0) begin
      nMismatched++; $display("[TB] FAIL reset_rd_data1 got %h want %h", o_rd_data1, 32'h0);
    end
    nCompared++;
    if (o_rd_vld1 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_rd_vld1 got %b want 0", o_rd_vld1);
    end
    nCompared++;
    if (o_ch_out !== '0) begin
      nMismatched++; $display("[TB] FAIL reset_ch_out got %h want 0", o_ch_out);
    end
    nCompared++;
    if (o_err !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_err got %b want 0", o_err);
    end
    nCompared++;
    if (o_conflict_cnt !== 8'd0) begin
      nMismatched++; $display("[TB] FAIL reset_conflict_cnt got %0d want 0", o_conflict_cnt);
    end
    #2 i_rst = 1'b0;
    commit();
    nCompared++;
    if (o_rd_data2 !== 32'h0 || o_rd_vld2 !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_abort_write got %h/%b want 0/0", o_rd_data2, o_rd_vld2);
    end
  endtask

  task automatic test_capture();
    idle();
    i_in_en = 1'b1; i_in_sel = 4'b0010; i_ch_in[1*DW +: DW] = 32'hA5A5_0001;
    i_ch_in[0*DW +: DW] = 32'h1111_1111; i_in_addr = 6'd5;
    commit();
    idle();
    i_rd_addr1 = 6'd5; i_rd_addr2 = 6'd6;
    #1;
    nCompared++;
    if (o_rd_data1 !== 32'hA5A5_0001) begin
      nMismatched++; $display("[TB] FAIL capture_data got %h want %h", o_rd_data1, 32'hA5A5_0001);
    end
    nCompared++;
    if (o_rd_vld1 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL capture_vld got %b want 1", o_rd_vld1);
    end
    nCompared++;
    if (o_rd_vld2 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL capture_other_vld got %b want 0", o_rd_vld2);
    end
  endtask

  task automatic test_collision();
    idle();
    i_in_en = 1'b1; i_in_sel = 4'b0001; i_ch_in[0*DW +: DW] = 32'h0000_FFFF;
    i_in_addr = 6'd9; i_wb_en = 1'b1; i_wb_addr = 6'd9; i_wb_data = 32'h0000_1234;
    commit();
    i_rd_addr1 = 6'd9;
    #1;
    nCompared++;
    if (o_rd_data1 !== 32'h0000_1234) begin
      nMismatched++; $display("[TB] FAIL collision_wb_wins got %h want %h", o_rd_data1, 32'h0000_1234);
    end
    nCompared++;
    if (o_conflict_cnt !== 8'd1) begin
      nMismatched++; $display("[TB] FAIL collision_cnt1 got %0d want 1", o_conflict_cnt);
    end
    for (int i = 0; i < 253; i++) commit();
    nCompared++;
    if (o_conflict_cnt !== 8'd254) begin
      nMismatched++; $display("[TB] FAIL collision_cnt254 got %0d want 254", o_conflict_cnt);
    end
    for (int i = 0; i < 46; i++) commit();
    nCompared++;
    if (o_conflict_cnt !== 8'd255) begin
      nMismatched++; $display("[TB] FAIL collision_saturate got %0d want 255", o_conflict_cnt);
    end
    // Different addresses: both commit, counter untouched.
    i_in_addr = 6'd10; i_wb_addr = 6'd11; i_wb_data = 32'h0000_5678;
    commit();
    idle();
    i_rd_addr1 = 6'd10; i_rd_addr2 = 6'd11;
    #1;
    nCompared++;
    if (o_rd_data1 !== 32'h0000_FFFF || o_rd_data2 !== 32'h0000_5678) begin
      nMismatched++;
      $display("[TB] FAIL dual_write got %h/%h want %h/%h", o_rd_data1, o_rd_data2, 32'h0000_FFFF, 32'h0000_5678);
    end
    nCompared++;
    if (o_conflict_cnt !== 8'd255 || o_err !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL dual_write_flags got cnt=%0d err=%b want cnt=255 err=0", o_conflict_cnt, o_err);
    end
  endtask

  task automatic test_illegal_select();
    idle();
    i_in_en = 1'b1; i_in_sel = 4'b0110; i_in_addr = 6'd5;
    i_ch_in[1*DW +: DW] = 32'h2222_2222; i_ch_in[2*DW +: DW] = 32'h4444_4444;
    commit();
    idle();
    i_rd_addr1 = 6'd5;
    #1;
    nCompared++;
    if (o_rd_data1 !== 32'hA5A5_0001) begin
      nMismatched++; $display("[TB] FAIL illegal_no_write got %h want %h", o_rd_data1, 32'hA5A5_0001);
    end
    nCompared++;
    if (o_err !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL illegal_err got %b want 1", o_err);
    end
    i_cfg_clr = 1'b1;
    commit();
    i_cfg_clr = 1'b0;
    #1;
    nCompared++;
    if (o_err !== 1'b0 || o_conflict_cnt !== 8'd0) begin
      nMismatched++;
      $display("[TB] FAIL cfg_clr_flags got err=%b cnt=%0d want err=0 cnt=0", o_err, o_conflict_cnt);
    end
    // Illegal bypass code reads as zero/invalid and flags at the edge.
    i_rd_byp1 = 4'b0011; i_ch_in[0*DW +: DW] = 32'h0000_0099;
    #1;
    nCompared++;
    if (o_rd_data1 !== 32'h0 || o_rd_vld1 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL illegal_byp_read got %h/%b want 0/0", o_rd_data1, o_rd_vld1);
    end
    commit();
    idle();
    #1;
    nCompared++;
    if (o_err !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL illegal_byp_err got %b want 1", o_err);
    end
    i_cfg_clr = 1'b1;
    commit();
    idle();
  endtask

  task automatic test_bypass_send();
    idle();
    i_rd_byp2 = 4'b1000; i_ch_in[3*DW +: DW] = 32'd7;
    i_rd_byp1 = 4'b0100; i_ch_in[2*DW +: DW] = 32'hCAFE_0002;
    i_send_addr = 6'd5; i_send_mask = 4'b0101;
    #1;
    nCompared++;
    if (o_rd_data2 !== 32'd7 || o_rd_vld2 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL bypass2 got %h/%b want %h/1", o_rd_data2, o_rd_vld2, 32'd7);
    end
    nCompared++;
    if (o_rd_data1 !== 32'hCAFE_0002 || o_rd_vld1 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL bypass1 got %h/%b want %h/1", o_rd_data1, o_rd_vld1, 32'hCAFE_0002);
    end
    nCompared++;
    if (o_ch_out !== {32'h0, 32'hA5A5_0001, 32'h0, 32'hA5A5_0001}) begin
      nMismatched++;
      $display("[TB] FAIL send_mask0101 got %h want %h", o_ch_out, {32'h0, 32'hA5A5_0001, 32'h0, 32'hA5A5_0001});
    end
    i_send_addr = 6'd11; i_send_mask = 4'b1010;
    #1;
    nCompared++;
    if (o_ch_out !== {32'h0000_5678, 32'h0, 32'h0000_5678, 32'h0}) begin
      nMismatched++;
      $display("[TB] FAIL send_mask1010 got %h want %h", o_ch_out, {32'h0000_5678, 32'h0, 32'h0000_5678, 32'h0});
    end
    commit();
    nCompared++;
    if (o_err !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL bypass_no_err got %b want 0", o_err);
    end
  endtask

  task automatic test_clear_vs_write();
    idle();
    // Re-validate register 5 with its original value.
    i_in_en = 1'b1; i_in_sel = 4'b0010; i_ch_in[1*DW +: DW] = 32'hA5A5_0001; i_in_addr = 6'd5;
    commit();
    idle();
    i_cfg_clr = 1'b1; i_wb_en = 1'b1; i_wb_addr = 6'd3; i_wb_data = 32'h0000_0033;
    commit();
    idle();
    i_rd_addr1 = 6'd3; i_rd_addr2 = 6'd5;
    #1;
    nCompared++;
    if (o_rd_vld1 !== 1'b1 || o_rd_data1 !== 32'h0000_0033) begin
      nMismatched++;
      $display("[TB] FAIL clr_write_wins got %h/%b want %h/1", o_rd_data1, o_rd_vld1, 32'h0000_0033);
    end
    nCompared++;
    if (o_rd_vld2 !== 1'b0 || o_rd_data2 !== 32'hA5A5_0001) begin
      nMismatched++;
      $display("[TB] FAIL clr_keeps_data got %h/%b want %h/0", o_rd_data2, o_rd_vld2, 32'hA5A5_0001);
    end
    // Three collisions, then a clear with a collision and an error in the same edge.
    i_in_en = 1'b1; i_in_sel = 4'b0001; i_in_addr = 6'd7; i_wb_en = 1'b1; i_wb_addr = 6'd7;
    for (int i = 0; i < 3; i++) commit();
    nCompared++;
    if (o_conflict_cnt !== 8'd3) begin
      nMismatched++; $display("[TB] FAIL pre_clr_cnt got %0d want 3", o_conflict_cnt);
    end
    i_cfg_clr = 1'b1; i_rd_byp2 = 4'b1001;
    commit();
    idle();
    #1;
    nCompared++;
    if (o_conflict_cnt !== 8'd1 || o_err !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL clr_same_edge got cnt=%0d err=%b want cnt=1 err=1", o_conflict_cnt, o_err);
    end
  endtask

  // Run the scenarios in order and report.
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    i_rst = 1'b1;
    idle();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    test_reset();
    test_capture();
    test_collision();
    test_illegal_select();
    test_bypass_send();
    test_clear_vs_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
